// File: rtl/retire_tracker_pkg.sv
// rtl/retire_tracker_pkg.sv - shared types and helpers for the retire tracker
package retire_tracker_pkg;

    localparam int TRACE_ADDR_WIDTH = 16;

    typedef struct packed {
        logic [TRACE_ADDR_WIDTH-1:0] addr;
    } trace_entry_t;

    // Pointer width for a power-of-two ring; never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trace_ring.sv
// rtl/trace_ring.sv - circular address store with push/pop/clear and occupancy
module trace_ring
    import retire_tracker_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 8,
    localparam int PW        = ptr_w(DEPTH),
    localparam int OW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] head_data,
    output logic [OW-1:0]         occupancy,
    output logic                  full,
    output logic                  empty
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [OW-1:0] OCC_ONE = OW'(1);
    localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [OW-1:0]         occ_next;

    assign head_data = mem[rd_ptr];
    assign full      = (occupancy == OCC_MAX);
    assign empty     = (occupancy == '0);

    // A clear drops everything behind the head; a simultaneous push lands first in the new empty ring.
    always_comb begin
        occ_next = occupancy;
        if (clear) begin
            occ_next = push ? OCC_ONE : '0;
        end else if (push && !pop) begin
            occ_next = occupancy + OCC_ONE;
        end else if (pop && !push) begin
            occ_next = occupancy - OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (clear) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/retire_tracker.sv
// rtl/retire_tracker.sv - in-order fetch/retire tracker with retired PC stream and error flags
module retire_tracker
    import retire_tracker_pkg::*;
#(
    parameter int ADDR_WIDTH        = 16,
    parameter int DEPTH             = 8,
    parameter int CNT_WIDTH         = 32,
    parameter int FLUSH_KEEPS_FETCH = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [ADDR_WIDTH-1:0]      fetch_addr,
    input  logic                       retire_valid,
    input  logic                       flush,
    input  logic                       clear_errors,
    output logic                       retire_out_valid,
    output logic [ADDR_WIDTH-1:0]      retire_out_addr,
    output logic [CNT_WIDTH-1:0]       retired_count,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty,
    output logic                       err_overflow,
    output logic                       err_underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                  flush_evt;
    logic                  do_pop;
    logic                  do_push;
    logic                  do_clear;
    logic                  ovf_evt;
    logic                  unf_evt;
    logic [ADDR_WIDTH-1:0] head_data;

    // Pop is judged against the registered state, so a fetch into an empty ring cannot satisfy a same-cycle retire.
    always_comb begin
        flush_evt = retire_valid & flush;
        do_pop    = retire_valid & ~empty;
        do_clear  = flush_evt;
        do_push   = fetch_valid & (~full | do_pop);
        if (flush_evt && (FLUSH_KEEPS_FETCH == 0)) begin
            do_push = 1'b0;
        end
        ovf_evt   = fetch_valid & full & ~do_pop;
        unf_evt   = retire_valid & empty;
    end

    trace_ring #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .pop       (do_pop),
        .clear     (do_clear),
        .push_data (fetch_addr),
        .head_data (head_data),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_out_valid <= 1'b0;
            retire_out_addr  <= '0;
            retired_count    <= '0;
            err_overflow     <= 1'b0;
            err_underflow    <= 1'b0;
        end else begin
            retire_out_valid <= do_pop;
            if (do_pop) begin
                retire_out_addr <= head_data;
                retired_count   <= retired_count + CNT_ONE;
            end
            err_overflow  <= ovf_evt | (err_overflow  & ~clear_errors);
            err_underflow <= unf_evt | (err_underflow & ~clear_errors);
        end
    end

endmodule

// File: tb/tb_retire_tracker.sv
// tb/tb_retire_tracker.sv - scoreboard bench for retire_tracker with both flush-fetch policies
module tb_retire_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        retire_valid = 1'b0;
    logic        flush = 1'b0;
    logic        clear_errors = 1'b0;

    logic        v0, v1, f0, f1, e0, e1, ov0, ov1, un0, un1;
    logic [15:0] a0, a1;
    logic [31:0] c0, c1;
    logic [3:0]  o0, o1;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    int cnt0 = 0;
    int cnt1 = 0;

    always #5 clk = ~clk;

    retire_tracker #(.ADDR_WIDTH(16), .DEPTH(8), .CNT_WIDTH(32), .FLUSH_KEEPS_FETCH(0)) dut0 (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .retire_valid(retire_valid), .flush(flush), .clear_errors(clear_errors),
        .retire_out_valid(v0), .retire_out_addr(a0), .retired_count(c0), .occupancy(o0),
        .full(f0), .empty(e0), .err_overflow(ov0), .err_underflow(un0)
    );

    retire_tracker #(.ADDR_WIDTH(16), .DEPTH(8), .CNT_WIDTH(32), .FLUSH_KEEPS_FETCH(1)) dut1 (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .retire_valid(retire_valid), .flush(flush), .clear_errors(clear_errors),
        .retire_out_valid(v1), .retire_out_addr(a1), .retired_count(c1), .occupancy(o1),
        .full(f1), .empty(e1), .err_overflow(ov1), .err_underflow(un1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic fv, input logic [15:0] fa, input logic rv,
                        input logic fl, input logic ce);
        fetch_valid  = fv;
        fetch_addr   = fa;
        retire_valid = rv;
        flush        = fl;
        clear_errors = ce;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retire pulse must match the head of that instance's expected queue.
    always @(negedge clk) begin
        if (v0) begin
            cnt0++;
            if (exp0.size() == 0) begin
                check("dut0 unexpected retire", a0, 16'hFFFF);
            end else begin
                check("dut0 retire addr", a0, exp0.pop_front());
                check("dut0 retired_count", c0, cnt0);
            end
        end
        if (v1) begin
            cnt1++;
            if (exp1.size() == 0) begin
                check("dut1 unexpected retire", a1, 16'hFFFF);
            end else begin
                check("dut1 retire addr", a1, exp1.pop_front());
                check("dut1 retired_count", c1, cnt1);
            end
        end
        if (rst) begin
            cnt0 = 0;
            cnt1 = 0;
        end
    end

    initial begin
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset occupancy", o0, 0);
        check("reset empty", e0, 1);
        check("reset full", f0, 0);
        check("reset retire_out_valid", v0, 0);
        check("reset retire_out_addr", a0, 0);
        check("reset retired_count", c0, 0);
        check("reset flags", {ov0, un0, ov1, un1}, 0);
        rst = 1'b0;

        // In-order retire of four fetches
        for (int i = 0; i < 4; i++) step(1, 16'(i), 0, 0, 0);
        check("four fetched occupancy", o0, 4);
        for (int i = 0; i < 4; i++) begin
            exp0.push_back(16'(i));
            exp1.push_back(16'(i));
            step(0, 0, 1, 0, 0);
        end
        step(0, 0, 0, 0, 0);
        check("count after four", c0, 4);
        check("empty after four", e0, 1);

        // Overflow: ninth fetch dropped
        for (int i = 0; i < 9; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("overflow full", f0, 1);
        check("overflow flag", ov0, 1);
        check("overflow occupancy", o0, 8);
        for (int i = 0; i < 8; i++) begin
            exp0.push_back(16'h0100 + 16'(i));
            exp1.push_back(16'h0100 + 16'(i));
            step(0, 0, 1, 0, 0);
        end
        step(0, 0, 0, 0, 0);
        check("drained empty", e0, 1);
        check("drained count", c0, 12);
        step(0, 0, 0, 0, 1);
        check("overflow cleared", ov0, 0);

        // Underflow
        step(0, 0, 1, 0, 0);
        check("underflow flag", un0, 1);
        check("underflow no valid", v0, 0);
        check("underflow count held", c0, 12);
        step(0, 0, 0, 0, 1);
        check("underflow cleared", un0, 0);

        // Flush with same-cycle fetch under both policies
        for (int i = 0; i < 5; i++) step(1, 16'h0010 + 16'(i), 0, 0, 0);
        check("pre-flush occupancy", o0, 5);
        exp0.push_back(16'h0010);
        exp1.push_back(16'h0010);
        step(1, 16'h0040, 1, 1, 0);
        check("flush keep0 occupancy", o0, 0);
        check("flush keep1 occupancy", o1, 1);
        check("flush keep0 no overflow", ov0, 0);
        exp1.push_back(16'h0040);
        step(0, 0, 1, 0, 0);
        check("flush keep0 then underflow", un0, 1);
        check("flush keep1 no underflow", un1, 0);
        step(0, 0, 0, 0, 1);
        check("keep1 count", c1, 14);
        check("keep0 count", c0, 13);

        // Full ring streaming: push and pop every cycle, pointers wrap
        for (int i = 0; i < 8; i++) step(1, 16'h0200 + 16'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            exp0.push_back(16'h0200 + 16'(i));
            exp1.push_back(16'h0200 + 16'(i));
            step(1, 16'h0208 + 16'(i), 1, 0, 0);
        end
        check("stream no overflow", ov0, 0);
        check("stream keep1 no overflow", ov1, 0);
        check("stream full", f0, 1);
        check("stream occupancy", o1, 8);

        // Mid-run reset at occupancy 6
        for (int i = 0; i < 2; i++) begin
            exp0.push_back(16'h0214 + 16'(i));
            exp1.push_back(16'h0214 + 16'(i));
            step(0, 0, 1, 0, 0);
        end
        check("pre-reset occupancy", o0, 6);
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        check("mid reset occupancy", o0, 0);
        check("mid reset count", c0, 0);
        check("mid reset flags", {ov0, un0}, 0);
        check("mid reset valid", v0, 0);
        check("mid reset empty", e1, 1);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("dut0 pending expected retires", exp0.size(), 0);
        check("dut1 pending expected retires", exp1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
